ms_riscv32_mp_bus_arbiter: RTL
==============================

Name: ms_riscv32_mp_bus_arbiter

Overview:
Arbitrates the core's instruction-fetch port and data-memory (load/store) port onto one shared AHB-Lite master interface.
- Sits between stage_1 (fetch) / the stage2 memory interface and the system bus.
- Sequences address and data phases, handles wait states (hready) and error responses (hresp).
- Returns read data, valid and error to the correct requester.

Parameters:
STARVE_LIMIT, 4, max consecutive data grants while fetch is pending before fetch is forced to win (1..15)

Ports:
ms_riscv32_mp_clk_in  in  1  clock, all state on rising edge
ms_riscv32_mp_rst_in  in  1  reset, synchronous, active-high
if_req_in  in  1  fetch request, held until if_gnt_out
if_addr_in  in  32  fetch address (word aligned)
if_gnt_out  out  1  fetch address phase accepted this cycle
if_rdata_out  out  32  fetch read data
if_rvalid_out  out  1  fetch data phase complete (1-cycle pulse)
if_err_out  out  1  fetch bus error (qualifies if_rvalid_out)
dm_req_in  in  1  data request, held until dm_gnt_out
dm_wr_in  in  1  1 = store, 0 = load
dm_addr_in  in  32  data address
dm_wdata_in  in  32  store data
dm_mask_in  in  4  byte-lane mask
dm_gnt_out  out  1  data address phase accepted
dm_rdata_out  out  32  load data
dm_rvalid_out  out  1  data transfer complete (1-cycle pulse)
dm_err_out  out  1  data error (bus error or illegal mask)
haddr_out  out  32  AHB address
htrans_out  out  2  AHB transfer: 2'b00 IDLE, 2'b10 NONSEQ only
hwrite_out  out  1  AHB write
hsize_out  out  3  AHB size
hwdata_out  out  32  AHB write data (data phase)
hwmask_out  out  4  byte mask (data phase)
hrdata_in  in  32  AHB read data
hready_in  in  1  AHB ready
hresp_in  in  1  AHB error response

Behaviour:
- FSM has three states.
  - IDLE: no outstanding transfer.
  - DP_IF: fetch in data phase.
  - DP_DM: data access in data phase.
- Issue window:
  - Open in IDLE, or in DP_* in the cycle hready_in=1 and hresp_in=0.
  - In the window: grant one pending requester; drive haddr/htrans=NONSEQ/hwrite/hsize combinationally from it; assert its gnt; next state DP_IF or DP_DM.
  - No request in the window: htrans_out=IDLE, next state IDLE.
- Outside the window: htrans_out=2'b00, both gnt=0.
- Priority:
  - Data beats fetch by default.
  - starve_cnt counts consecutive dm grants while if_req_in=1. When it reaches STARVE_LIMIT, fetch wins the next window.
  - starve_cnt clears on any if grant, or when if_req_in=0.
- hsize_out:
  - Fetch always 3'b010.
  - Data: 1111→010; 0011 or 1100→001; single bit→000.
  - Any other mask is illegal: dm_gnt_out=1 and a dm_rvalid_out+dm_err_out pulse next cycle, with no bus transfer (htrans IDLE). This consumes the window.
- Data phase:
  - hwdata_out/hwmask_out come from registers captured at grant and are held until completion. Both are 0 when not in a store data phase.
  - Completion is the cycle hready_in=1. The owner's rvalid pulses and its rdata = hrdata_in; rdata is 0 for stores.
- Error:
  - hresp_in=1 with hready_in=0 (first error cycle): htrans_out forced IDLE, no grant.
  - hresp_in=1 with hready_in=1: owner's rvalid=1 and err=1; no grant that cycle; next state IDLE.
- Wait states: while hready_in=0 there are no grants and the state is held.
- Simultaneous requests with starve_cnt<STARVE_LIMIT: dm wins.
- Reset (sync, any state, including mid data phase):
  - State returns to IDLE; starve_cnt=0.
  - All outputs go to 0 (htrans IDLE).
  - The outstanding transfer is dropped with no rvalid.
- Latency: grant to rvalid is 1 cycle plus wait states. Back-to-back zero-wait transfers sustain 1 per cycle.

Optional Feature:
MS_RISCV32_MP_ARB_RR_EN
- Defined: strict round-robin. When both request, the requester not granted last wins. A last_gnt flag resets to "fetch" so data wins first. starve_cnt and STARVE_LIMIT are unused.
- Undefined: data priority with starvation limit as above.

Test Plan:
- Reset then if_req_in=1, if_addr_in=0x0000_0100, hready=1, hrdata=0x0000_0013 → cycle 0: if_gnt=1, htrans=2'b10, haddr=0x100, hsize=010. Cycle 1: if_rvalid=1, if_rdata=0x13.
- Store dm_addr=0x2000_0002, mask=1100, wdata=0xABCD_0000, hready low 2 cycles in data phase → hsize=001, hwrite=1. hwdata held 3 cycles. dm_rvalid on the 3rd cycle only. No grants during the wait.
- if_req and dm_req both held high, STARVE_LIMIT=4 → grant sequence dm,dm,dm,dm,if,dm…; with RR_EN: dm,if,dm,if.
- Load to 0x3000_0000 with hresp=1/hready=0 then hresp=1/hready=1 → htrans IDLE in both cycles. dm_rvalid=1 and dm_err=1 in the second cycle. Pending fetch is granted the following cycle.
- dm_mask=0101 → dm_gnt=1, htrans stays IDLE. Next cycle dm_rvalid=1, dm_err=1.
- Sync reset asserted during a fetch data phase with hready=0 → next edge: htrans=0, all outputs 0, no if_rvalid ever produced for that fetch.

Source files
------------

// File: rtl/ms_riscv32_mp_bus_arbiter.sv
// Shares one AHB-Lite master between the fetch port and the load/store port.
// Define MS_RISCV32_MP_ARB_RR_EN for round-robin; otherwise data wins, with a fetch starvation limit.
//
// state    | meaning
// ---------+-----------------------------------------
// ST_IDLE  | no outstanding transfer
// ST_DP_IF | fetch transfer in its data phase
// ST_DP_DM | load/store transfer in its data phase
module ms_riscv32_mp_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    output logic        if_gnt_out,
    output logic [31:0] if_rdata_out,
    output logic        if_rvalid_out,
    output logic        if_err_out,
    input  logic        dm_req_in,
    input  logic        dm_wr_in,
    input  logic [31:0] dm_addr_in,
    input  logic [31:0] dm_wdata_in,
    input  logic [3:0]  dm_mask_in,
    output logic        dm_gnt_out,
    output logic [31:0] dm_rdata_out,
    output logic        dm_rvalid_out,
    output logic        dm_err_out,
    output logic [31:0] haddr_out,
    output logic [1:0]  htrans_out,
    output logic        hwrite_out,
    output logic [2:0]  hsize_out,
    output logic [31:0] hwdata_out,
    output logic [3:0]  hwmask_out,
    input  logic [31:0] hrdata_in,
    input  logic        hready_in,
    input  logic        hresp_in
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DP_IF = 2'd1,
        ST_DP_DM = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic        ill_q, ill_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [3:0]  hwmask_q, hwmask_d;

    logic        rst;
    logic        win;
    logic        if_wins;
    logic        gnt_if;
    logic        gnt_dm;
    logic        issue_dm;
    logic        done;
    logic        dm_done;
    logic        mask_legal;
    logic [2:0]  mask_size;

    assign rst = ms_riscv32_mp_rst_in;

`ifdef MS_RISCV32_MP_ARB_RR_EN
    logic last_dm_q, last_dm_d;

    assign if_wins = if_req_in && (!dm_req_in || last_dm_q);
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;

    assign if_wins = if_req_in && (!dm_req_in || (starve_q >= STARVE_LIM));
`endif

    // Only word, aligned halfword and single-byte masks map to an AHB size.
    always_comb begin
        mask_legal = 1'b1;
        mask_size  = 3'b000;
        case (dm_mask_in)
            4'b1111:                            mask_size = 3'b010;
            4'b0011, 4'b1100:                   mask_size = 3'b001;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: mask_size = 3'b000;
            default:                            mask_legal = 1'b0;
        endcase
    end

    assign win      = !rst && ((state_q == ST_IDLE) || (hready_in && !hresp_in));
    assign gnt_if   = win && if_wins;
    assign gnt_dm   = win && dm_req_in && !if_wins;
    assign issue_dm = gnt_dm && mask_legal;
    assign done     = !rst && (state_q != ST_IDLE) && hready_in;
    assign dm_done  = done && (state_q == ST_DP_DM);

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (gnt_if) begin
            state_d = ST_DP_IF;
        end else if (issue_dm) begin
            state_d = ST_DP_DM;
        end else if (win) begin
            state_d = ST_IDLE;
        end else if ((state_q != ST_IDLE) && hready_in) begin
            // error completion closes the window but still retires the owner
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        if_gnt_out    = gnt_if;
        dm_gnt_out    = gnt_dm;
        htrans_out    = 2'b00;
        haddr_out     = '0;
        hwrite_out    = 1'b0;
        hsize_out     = 3'b000;
        if (gnt_if) begin
            htrans_out = 2'b10;
            haddr_out  = if_addr_in;
            hsize_out  = 3'b010;
        end else if (issue_dm) begin
            htrans_out = 2'b10;
            haddr_out  = dm_addr_in;
            hwrite_out = dm_wr_in;
            hsize_out  = mask_size;
        end
        hwdata_out    = hwdata_q;
        hwmask_out    = hwmask_q;
        if_rvalid_out = done && (state_q == ST_DP_IF);
        if_err_out    = done && (state_q == ST_DP_IF) && hresp_in;
        if_rdata_out  = (done && (state_q == ST_DP_IF)) ? hrdata_in : '0;
        dm_rvalid_out = dm_done || (ill_q && !rst);
        dm_err_out    = (dm_done && hresp_in) || (ill_q && !rst);
        dm_rdata_out  = (dm_done && !wr_q) ? hrdata_in : '0;
    end

    // Store data/mask are reloaded only when the data phase advances.
    always_comb begin
        wr_d     = wr_q;
        hwdata_d = hwdata_q;
        hwmask_d = hwmask_q;
        ill_d    = gnt_dm && !mask_legal;
        if ((state_q == ST_IDLE) || hready_in) begin
            wr_d     = issue_dm && dm_wr_in;
            hwdata_d = (issue_dm && dm_wr_in) ? dm_wdata_in : '0;
            hwmask_d = (issue_dm && dm_wr_in) ? dm_mask_in : '0;
        end
`ifdef MS_RISCV32_MP_ARB_RR_EN
        last_dm_d = last_dm_q;
        if (gnt_if) begin
            last_dm_d = 1'b0;
        end else if (gnt_dm) begin
            last_dm_d = 1'b1;
        end
`else
        starve_d = starve_q;
        if (!if_req_in || gnt_if) begin
            starve_d = '0;
        end else if (gnt_dm && (starve_q != 4'hF)) begin
            starve_d = starve_q + 4'd1;
        end
`endif
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (rst) begin
            wr_q      <= 1'b0;
            ill_q     <= 1'b0;
            hwdata_q  <= '0;
            hwmask_q  <= '0;
`ifdef MS_RISCV32_MP_ARB_RR_EN
            last_dm_q <= 1'b0;
`else
            starve_q  <= '0;
`endif
        end else begin
            wr_q      <= wr_d;
            ill_q     <= ill_d;
            hwdata_q  <= hwdata_d;
            hwmask_q  <= hwmask_d;
`ifdef MS_RISCV32_MP_ARB_RR_EN
            last_dm_q <= last_dm_d;
`else
            starve_q  <= starve_d;
`endif
        end
    end

endmodule
